// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader writing 19-bit words into CPU instruction memory (optional checksum: PROGRAM_LOADER_CHECKSUM_EN)
module program_loader #(
  parameter logic [18:0] BASE_ADDR = 19'd0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write,
  output logic [18:0] mem_address,
  output logic [18:0] mem_write_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [18:0] word_count
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN2, S_LEN1, S_LEN0,
    S_D0, S_D1, S_D2, S_WR, S_CHK, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN2, S_LEN1, S_LEN0,
    S_D0, S_D1, S_D2, S_WR, S_DONE, S_ERROR
  } state_t;
`endif

  state_t      state;
  state_t      state_next;

  logic [2:0]  len_hi;
  logic [7:0]  len_mid;
  logic [18:0] len_words;
  logic [2:0]  word_hi;
  logic [7:0]  word_mid;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_xor;
`endif

  logic        accept;
  logic        start_ok;
  logic [18:0] len_from_stream;
  logic        last_word;

  assign accept          = byte_valid & byte_ready;
  assign len_from_stream = {len_hi, len_mid, byte_data};
  assign last_word       = ((word_count + 19'd1) == len_words);

  // State register; reset aborts any session and drops the write strobe at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_write  = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    start_ok   = 1'b0;
    case (state)
      S_IDLE: begin
        start_ok = start;
        if (start) state_next = S_SYNC;
      end
      S_SYNC: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept && byte_data == SYNC_BYTE) state_next = S_LEN2;
      end
      S_LEN2: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) state_next = S_LEN1;
      end
      S_LEN1: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) state_next = S_LEN0;
      end
      S_LEN0: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) begin
          if (len_from_stream != 19'd0) begin
            state_next = S_D0;
          end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_DONE;
`endif
          end
        end
      end
      S_D0: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) begin
          if (byte_data[7:3] != 5'd0) state_next = S_ERROR;
          else                        state_next = S_D1;
        end
      end
      S_D1: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) state_next = S_D2;
      end
      S_D2: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) state_next = S_WR;
      end
      S_WR: begin
        mem_write = 1'b1;
        cpu_hold  = 1'b1;
        if (!last_word) begin
          state_next = S_D0;
        end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept) begin
          if (byte_data == chk_xor) state_next = S_DONE;
          else                      state_next = S_ERROR;
        end
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        start_ok = start;
        if (start) state_next = S_SYNC;
      end
      S_ERROR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        start_ok = start;
        if (start) state_next = S_SYNC;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: length capture, word assembly, write address/data and word counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_hi         <= 3'd0;
      len_mid        <= 8'd0;
      len_words      <= 19'd0;
      word_hi        <= 3'd0;
      word_mid       <= 8'd0;
      mem_address    <= 19'd0;
      mem_write_data <= 19'd0;
      word_count     <= 19'd0;
    end else begin
      if (start_ok) begin
        word_count <= 19'd0;
      end
      if (accept) begin
        case (state)
          S_LEN2: len_hi    <= byte_data[2:0];
          S_LEN1: len_mid   <= byte_data;
          S_LEN0: len_words <= len_from_stream;
          S_D0:   word_hi   <= byte_data[2:0];
          S_D1:   word_mid  <= byte_data;
          S_D2: begin
            mem_write_data <= {word_hi, word_mid, byte_data};
            mem_address    <= BASE_ADDR + word_count;
          end
          default: begin
          end
        endcase
      end
      if (state == S_WR) begin
        word_count <= word_count + 19'd1;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR over the length and data bytes, restarted with each session
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_xor <= 8'd0;
    end else if (start_ok) begin
      chk_xor <= 8'd0;
    end else if (accept && state != S_SYNC && state != S_CHK) begin
      chk_xor <= chk_xor ^ byte_data;
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        sel = 1'b0;

  logic        rdy0, mw0, hold0, done0, err0;
  logic [18:0] ma0, md0, wc0;
  logic        rdy1, mw1, hold1, done1, err1;
  logic [18:0] ma1, md1, wc1;

  int total = 0;
  int bad = 0;

  logic [18:0] wa [0:63];
  logic [18:0] wd [0:63];
  int          wtotal = 0;
  int          base;
  logic [7:0]  frame [$];

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(19'd0), .SYNC_BYTE(8'hA5)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(rdy0),
    .mem_write(mw0), .mem_address(ma0), .mem_write_data(md0),
    .cpu_hold(hold0), .done(done0), .error(err0), .word_count(wc0)
  );

  program_loader #(.BASE_ADDR(19'h7FFFF), .SYNC_BYTE(8'hA5)) u_wrap (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(rdy1),
    .mem_write(mw1), .mem_address(ma1), .mem_write_data(md1),
    .cpu_hold(hold1), .done(done1), .error(err1), .word_count(wc1)
  );

  wire        rdy  = sel ? rdy1  : rdy0;
  wire        mw   = sel ? mw1   : mw0;
  wire        hold = sel ? hold1 : hold0;
  wire        dn   = sel ? done1 : done0;
  wire        er   = sel ? err1  : err0;
  wire [18:0] ma   = sel ? ma1   : ma0;
  wire [18:0] md   = sel ? md1   : md0;
  wire [18:0] wc   = sel ? wc1   : wc0;

  // Record every write strobe of the selected instance, sampled mid-cycle
  always @(negedge clk) begin
    if (mw) begin
      wa[wtotal & 63] <= ma;
      wd[wtotal & 63] <= md;
      wtotal <= wtotal + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 40 && !got; i++) begin
      if (rdy) got = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_byte_timeout byte=%h ready=%b required=1", b, rdy);
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i]);
  endtask

  task automatic pulse_start(input bit which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start0     = 1'($urandom);
      start1     = 1'($urandom);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_byte_ready got=%b exp=0", rdy0); end
    total++; if (mw0 !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", mw0); end
    total++; if (ma0 !== 19'd0) begin bad++; $display("FAIL reset_mem_address got=%h exp=0", ma0); end
    total++; if (md0 !== 19'd0) begin bad++; $display("FAIL reset_mem_write_data got=%h exp=0", md0); end
    total++; if (hold0 !== 1'b0) begin bad++; $display("FAIL reset_cpu_hold got=%b exp=0", hold0); end
    total++; if (done0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", done0, err0); end
    total++; if (wc0 !== 19'd0) begin bad++; $display("FAIL reset_word_count got=%h exp=0", wc0); end
    total++; if (rdy1 !== 1'b0 || hold1 !== 1'b0) begin bad++; $display("FAIL reset_wrap_inst got=%b%b exp=00", rdy1, hold1); end
    start0 = 1'b0; start1 = 1'b0; byte_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL idle_byte_ready got=%b exp=0", rdy0); end
  endtask

  task automatic test_good_load();
    base = wtotal;
    pulse_start(1'b0);
    total++; if (rdy !== 1'b1 || hold !== 1'b1) begin bad++; $display("FAIL start_latency got=%b%b exp=11", rdy, hold); end
    frame = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF};
    send_frame();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h62);
`else
    @(posedge clk); #1;
`endif
    byte_valid = 1'b0;
    total++; if (dn !== 1'b1 || er !== 1'b0) begin bad++; $display("FAIL good_flags got=%b%b exp=10", dn, er); end
    total++; if (wtotal - base !== 2) begin bad++; $display("FAIL good_write_count got=%0d exp=2", wtotal - base); end
    total++; if (wa[base & 63] !== 19'h00000 || wd[base & 63] !== 19'h12345) begin bad++; $display("FAIL good_word0 got=%h:%h exp=00000:12345", wa[base & 63], wd[base & 63]); end
    total++; if (wa[(base + 1) & 63] !== 19'h00001 || wd[(base + 1) & 63] !== 19'h7FFFF) begin bad++; $display("FAIL good_word1 got=%h:%h exp=00001:7ffff", wa[(base + 1) & 63], wd[(base + 1) & 63]); end
    total++; if (wc !== 19'd2) begin bad++; $display("FAIL good_word_count got=%0d exp=2", wc); end
    total++; if (hold !== 1'b0 || rdy !== 1'b0) begin bad++; $display("FAIL good_release got=%b%b exp=00", hold, rdy); end
  endtask

  task automatic test_bad_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    base = wtotal;
    pulse_start(1'b0);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h63};
    send_frame();
    byte_valid = 1'b0;
    total++; if (er !== 1'b1 || dn !== 1'b0) begin bad++; $display("FAIL badchk_flags got=%b%b exp=01", er, dn); end
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL badchk_hold got=%b exp=1", hold); end
    total++; if (wtotal - base !== 2) begin bad++; $display("FAIL badchk_writes got=%0d exp=2", wtotal - base); end
    pulse_start(1'b0);
    total++; if (er !== 1'b0 || dn !== 1'b0 || wc !== 19'd0) begin bad++; $display("FAIL badchk_clear got=%b%b wc=%0d exp=00 wc=0", er, dn, wc); end
`endif
  endtask

  task automatic test_empty_frame(input bit need_start);
    base = wtotal;
    if (need_start) pulse_start(1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
`endif
    send_frame();
    byte_valid = 1'b0;
    total++; if (dn !== 1'b1 || er !== 1'b0) begin bad++; $display("FAIL empty_flags got=%b%b exp=10", dn, er); end
    total++; if (wtotal - base !== 0 || wc !== 19'd0) begin bad++; $display("FAIL empty_writes got=%0d wc=%0d exp=0", wtotal - base, wc); end
  endtask

  task automatic test_resync_backpressure();
    base = wtotal;
    pulse_start(1'b0);
    frame = '{8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    send_frame();
    total++; if (wtotal - base !== 0 || mw !== 1'b0) begin bad++; $display("FAIL resync_early_write got=%0d/%b exp=0/0", wtotal - base, mw); end
    send_byte(8'h07);
    total++; if (mw !== 1'b1 || rdy !== 1'b0) begin bad++; $display("FAIL wr_cycle got=%b%b exp=10", mw, rdy); end
    total++; if (ma !== 19'd0 || md !== 19'h00007) begin bad++; $display("FAIL wr_addr_data got=%h:%h exp=00000:00007", ma, md); end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h06);
`else
    @(posedge clk); #1;
`endif
    byte_valid = 1'b0;
    total++; if (dn !== 1'b1 || wc !== 19'd1) begin bad++; $display("FAIL resync_done got=%b wc=%0d exp=1 wc=1", dn, wc); end
    total++; if (wtotal - base !== 1) begin bad++; $display("FAIL resync_writes got=%0d exp=1", wtotal - base); end
  endtask

  task automatic test_format_error();
    base = wtotal;
    pulse_start(1'b0);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h08};
    send_frame();
    total++; if (er !== 1'b1 || dn !== 1'b0) begin bad++; $display("FAIL fmt_flags got=%b%b exp=01", er, dn); end
    total++; if (hold !== 1'b1 || rdy !== 1'b0) begin bad++; $display("FAIL fmt_hold_ready got=%b%b exp=10", hold, rdy); end
    repeat (3) begin @(posedge clk); #1; end
    byte_valid = 1'b0;
    total++; if (wtotal - base !== 0 || wc !== 19'd0) begin bad++; $display("FAIL fmt_no_write got=%0d wc=%0d exp=0", wtotal - base, wc); end
    total++; if (er !== 1'b1) begin bad++; $display("FAIL fmt_sticky got=%b exp=1", er); end
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    base = wtotal;
    pulse_start(1'b1);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
    send_frame();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h01);
`else
    @(posedge clk); #1;
`endif
    byte_valid = 1'b0;
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", dn); end
    total++; if (wtotal - base !== 2) begin bad++; $display("FAIL wrap_writes got=%0d exp=2", wtotal - base); end
    total++; if (wa[base & 63] !== 19'h7FFFF || wd[base & 63] !== 19'h00001) begin bad++; $display("FAIL wrap_word0 got=%h:%h exp=7ffff:00001", wa[base & 63], wd[base & 63]); end
    total++; if (wa[(base + 1) & 63] !== 19'h00000 || wd[(base + 1) & 63] !== 19'h00002) begin bad++; $display("FAIL wrap_word1 got=%h:%h exp=00000:00002", wa[(base + 1) & 63], wd[(base + 1) & 63]); end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    base = wtotal;
    pulse_start(1'b0);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h01};
    send_frame();
    byte_data = 8'h23;
    #2 reset_n = 1'b0;
    #1;
    total++; if (mw !== 1'b0 || hold !== 1'b0 || rdy !== 1'b0) begin bad++; $display("FAIL abort_async got=%b%b%b exp=000", mw, hold, rdy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      byte_data = 8'(i + 3);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    total++; if (wtotal - base !== 0) begin bad++; $display("FAIL abort_no_write got=%0d exp=0", wtotal - base); end
    total++; if (rdy !== 1'b0 || hold !== 1'b0 || wc !== 19'd0) begin bad++; $display("FAIL abort_idle got=%b%b wc=%0d exp=00 wc=0", rdy, hold, wc); end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_empty_frame(1'b1);
    test_resync_backpressure();
    test_format_error();
    test_empty_frame(1'b1);
    test_wrap();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into the 19-bit CPU's instruction memory, driving the memory's write port so the CPU fetch path can then read it. Bytes arrive over a valid/ready byte stream and are framed, checked and packed into 19-bit words, each written at an incrementing address. The CPU is held off while a load is in progress. The block sits between the host link and the memory write port, in front of the CPU.

## Interface
- `BASE_ADDR`, default 0: memory address of the first loaded word (19 bits).
- `SYNC_BYTE`, default 8'hA5: frame header byte.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that opens a load session.
- `byte_valid` in 1: the byte source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: the loader accepts a byte. A transfer occurs on a rising edge with `byte_valid & byte_ready`.
- `mem_write` out 1: memory write strobe, one cycle per word.
- `mem_address` out 19: write address.
- `mem_write_data` out 19: write data.
- `cpu_hold` out 1: holds the CPU in reset while asserted.
- `done` out 1: sticky flag, the load completed successfully.
- `error` out 1: sticky flag, the load failed.
- `word_count` out 19: number of words written in the current session.

## Operation
- **Frame format:**
  - `SYNC_BYTE`.
  - LEN2, LEN1, LEN0: word count N, big-endian. Bits [18:0] are used; bits [23:19] are ignored.
  - N words, 3 bytes each, big-endian:
    - Byte 0 bits [2:0] are word bits [18:16].
    - Byte 0 bits [7:3] must be 0.
  - CHK (configurable): XOR of all LEN and data bytes.
- **States:**
  - IDLE → SYNC on `start`.
  - SYNC: a byte equal to `SYNC_BYTE` → LEN2. Any other byte is discarded and the block stays in SYNC.
  - LEN2 → LEN1 → LEN0. Leaving LEN0, go to D0 if N≠0, otherwise to CHK (or DONE when checksum is compiled out).
  - D0 → D1 → D2 → WR.
    - In D0, a byte with [7:3]≠0 → ERROR. No write occurs for that word.
  - WR: one cycle, then D0 if words remain, otherwise CHK or DONE.
  - CHK: received byte equals the running XOR → DONE, otherwise → ERROR.
  - DONE and ERROR: terminal. `start` → SYNC.
- **`start` behaviour:**
  - Ignored in every state except IDLE, DONE and ERROR.
  - On acceptance, clears `done`, `error`, `word_count` and the running XOR.
- **Write address:** the address written in WR is `BASE_ADDR + word_count`, mod 2^19 (wraps past 19'h7FFFF to 0). `word_count` increments at the end of WR.
- **`cpu_hold`:**
  - 1 in SYNC through CHK, and in ERROR.
  - 0 in IDLE and DONE.
  - A failed load never releases the CPU.
- **`byte_ready`:**
  - 1 in SYNC, LEN*, D*, and CHK.
  - 0 in IDLE, WR, DONE and ERROR.
  - When `byte_valid` is high while `byte_ready` is low, no byte is consumed.
- **Reset:** asserting `reset_n` low mid-session aborts immediately:
  - `mem_write` drops asynchronously.
  - The state returns to IDLE.
  - The partially written image is left in memory.

## Timing
- Reset values: `byte_ready`=0, `mem_write`=0, `mem_address`=0, `mem_write_data`=0, `cpu_hold`=0, `done`=0, `error`=0, `word_count`=0.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- `start` sampled at edge E: `byte_ready`=1 and `cpu_hold`=1 from cycle E+1.
- D2 byte accepted at edge E: `mem_write`=1 with valid address and data during cycle E+1 (exactly one cycle). The next byte is accepted no earlier than edge E+2.
- Peak throughput: 3 bytes per 4 cycles.
- `done` or `error` rises in the cycle after the final byte (CHK byte, or last D2 byte's WR) is accepted. The flag holds until `start` or reset.
- Format-error and checksum-error transitions to ERROR are 1 cycle after the offending byte.

## Configuration
- Macro `PROGRAM_LOADER_CHECKSUM_EN`.
  - **Defined:** the CHK byte is required and compared. A mismatch → ERROR.
  - **Undefined:**
    - There is no CHK state and no XOR register.
    - After the last WR (or LEN0 with N=0), go to DONE.
    - ERROR is reachable only by a format error.

## Test plan
- **Reset:** assert `reset_n`=0 with random inputs → all outputs at reset values, `byte_ready`=0.
- **Good load:** `start`; A5 00 00 02 01 23 45 07 FF FF 62 → write 19'h12345 at 0 and 19'h7FFFF at 1. Then `done`=1, `word_count`=2, `cpu_hold`=0.
- **Bad checksum:** same frame with CHK 63 → both words written, `error`=1, `done`=0, `cpu_hold`=1. A following `start` clears `error`.
- **Resync and backpressure:** 00 5A before A5 are discarded. `byte_valid` held high throughout yields no byte loss across WR cycles. A one-word frame (A5 00 00 01 00 00 07, CHK 06) writes 19'h00007.
- **Format error:** D0 byte 08 → `error`=1 next cycle, no `mem_write`, `word_count` unchanged.
- **Wrap and abort:**
  - With `BASE_ADDR`=19'h7FFFF, a 2-word load writes addresses 7FFFF then 00000.
  - `reset_n` low during D1 → IDLE, `cpu_hold`=0, no further writes.
